// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter sharing one memory port among
// NUM_PORTS caches, with write-invalidate broadcast to the other caches.
module memory_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [25*NUM_PORTS-1:0]   cache_request,
  input  logic [NUM_PORTS-1:0]      cache_request_ready,
  output logic [15:0]               cache_response,
  output logic [NUM_PORTS-1:0]      cache_response_ready,
  output logic [16*NUM_PORTS-1:0]   invalidate_address,
  output logic [24:0]               memory_request,
  output logic                      memory_request_ready,
  input  logic [15:0]               memory_response,
  input  logic                      memory_response_ready,
  output logic                      timeout_error
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_RESPOND  = 3'd3;
  localparam logic [2:0] S_COOLDOWN = 3'd4;

  // The counter value seen on the last waiting cycle before the abort.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]              state_q, state_d;
  logic [PTR_W-1:0]        rr_q, rr_d;
  logic [PTR_W-1:0]        grant_q, grant_d;
  logic [24:0]             req_q, req_d;
  logic [24:0]             mreq_q, mreq_d;
  logic                    mrdy_q, mrdy_d;
  logic [15:0]             rdata_q, rdata_d;
  logic                    tout_q, tout_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [15:0]             cresp_q, cresp_d;
  logic [NUM_PORTS-1:0]    crdy_q, crdy_d;
  logic [16*NUM_PORTS-1:0] inval_q, inval_d;
  logic [NUM_PORTS-1:0]    pend_q, pend_d;
  logic                    terr_q, terr_d;

  logic [24:0]             req_arr [NUM_PORTS];
  logic                    found;
  logic [PTR_W-1:0]        pick;

  // Unpack the flat request bus into per-port slots.
  always_comb begin
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      req_arr[k] = cache_request[25*k +: 25];
    end
  end

  // Round-robin scan starting at rr_q, wrapping modulo NUM_PORTS.
  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] idx_p;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_p = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      idx_p = PTR_W'(idx);
      if (!found && cache_request_ready[idx_p]) begin
        found = 1'b1;
        pick  = idx_p;
      end
    end
  end

  // Next-state logic for the transaction FSM and all registered outputs.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    req_d   = req_q;
    mreq_d  = mreq_q;
    mrdy_d  = mrdy_q;
    rdata_d = rdata_q;
    tout_d  = tout_q;
    cnt_d   = cnt_q;
    cresp_d = cresp_q;
    crdy_d  = '0;
    inval_d = inval_q;
    pend_d  = pend_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_d   = req_arr[pick];
          grant_d = pick;
          tout_d  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mreq_d  = req_q;
        mrdy_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (memory_response_ready) begin
          rdata_d = memory_response;
          mrdy_d  = 1'b0;
          state_d = S_RESPOND;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          mrdy_d  = 1'b0;
          tout_d  = 1'b1;
          terr_d  = 1'b1;
          state_d = S_RESPOND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESPOND: begin
        cresp_d         = rdata_q;
        crdy_d[grant_q] = 1'b1;
        if (req_q[24] && !tout_q) begin
          for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (PTR_W'(j) != grant_q) begin
              if (inval_q[16*j +: 16] != req_q[15:0]) begin
                inval_d[16*j +: 16] = req_q[15:0];
              end else begin
                // Same address again: flip the tag for one cycle so the
                // cache still sees a change, then restore in COOLDOWN.
                inval_d[16*j +: 16] = {~req_q[15:8], req_q[7:0]};
                pend_d[j]           = 1'b1;
              end
            end
          end
        end
        if (grant_q == PTR_W'(NUM_PORTS - 1)) rr_d = '0;
        else                                  rr_d = grant_q + PTR_W'(1);
        state_d = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
          if (pend_q[j]) inval_d[16*j +: 16] = req_q[15:0];
        end
        pend_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      req_q   <= '0;
      mreq_q  <= '0;
      mrdy_q  <= 1'b0;
      rdata_q <= '0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
      cresp_q <= '0;
      crdy_q  <= '0;
      inval_q <= '0;
      pend_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      req_q   <= req_d;
      mreq_q  <= mreq_d;
      mrdy_q  <= mrdy_d;
      rdata_q <= rdata_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
      cresp_q <= cresp_d;
      crdy_q  <= crdy_d;
      inval_q <= inval_d;
      pend_q  <= pend_d;
      terr_q  <= terr_d;
    end
  end

  assign cache_response       = cresp_q;
  assign cache_response_ready = crdy_q;
  assign invalidate_address   = inval_q;
  assign memory_request       = mreq_q;
  assign memory_request_ready = mrdy_q;
  assign timeout_error        = terr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (NUM_PORTS = 2).
module tb_memory_arbiter;

  logic        clock;
  logic        reset;
  logic [49:0] cache_request;
  logic [1:0]  cache_request_ready;
  logic [15:0] cache_response;
  logic [1:0]  cache_response_ready;
  logic [31:0] invalidate_address;
  logic [24:0] memory_request;
  logic        memory_request_ready;
  logic [15:0] memory_response;
  logic        memory_response_ready;
  logic        timeout_error;

  int tests = 0;
  int fails = 0;

  memory_arbiter #(.NUM_PORTS(2), .TIMEOUT_CYCLES(255)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .cache_request         (cache_request),
    .cache_request_ready   (cache_request_ready),
    .cache_response        (cache_response),
    .cache_response_ready  (cache_response_ready),
    .invalidate_address    (invalidate_address),
    .memory_request        (memory_request),
    .memory_request_ready  (memory_request_ready),
    .memory_response       (memory_response),
    .memory_response_ready (memory_response_ready),
    .timeout_error         (timeout_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_mreq(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (memory_request_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_mreq_seen"}, 32'(ok), 32'd1);
  endtask

  // One transaction: raise the port's ready, act as memory after `delay`
  // waiting cycles, and check the response pulse one cycle later.
  task automatic txn(input int port, input logic [24:0] req, input logic [15:0] rdata,
                     input int delay, input string tag);
    cache_request[25*port +: 25] = req;
    cache_request_ready[port]    = 1'b1;
    wait_mreq(tag);
    check({tag, "_mreq"}, 32'(memory_request), 32'(req));
    repeat (delay) tick();
    memory_response       = rdata;
    memory_response_ready = 1'b1;
    tick();
    memory_response_ready = 1'b0;
    check({tag, "_no_early_rdy"}, 32'(cache_response_ready), 32'd0);
    tick();
    check({tag, "_rdy"}, 32'(cache_response_ready), 32'(2'b01 << port));
    check({tag, "_resp"}, 32'(cache_response), 32'(rdata));
    cache_request_ready[port] = 1'b0;
  endtask

  initial begin
    int cnt;
    reset                 = 1'b0;
    cache_request         = '0;
    cache_request_ready   = '0;
    memory_response       = '0;
    memory_response_ready = 1'b0;
    #1;
    check("rst_mreq_rdy", 32'(memory_request_ready), 32'd0);
    check("rst_crdy", 32'(cache_response_ready), 32'd0);
    check("rst_inval", invalidate_address, 32'd0);
    check("rst_terr", 32'(timeout_error), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // 1: single read from port 0, memory answers after 3 cycles
    txn(0, {1'b0, 8'h00, 16'h1234}, 16'hBEEF, 3, "t1");
    check("t1_inval", invalidate_address, 32'd0);
    tick();
    check("t1_pulse_end", 32'(cache_response_ready), 32'd0);

    // bring rr_pointer back to 0 with a port-1 read
    txn(1, {1'b0, 8'h00, 16'h0010}, 16'h1111, 0, "t2pre");
    tick();

    // 2: contention with rr_pointer=0 -> port 0, then port 1
    cache_request[49:25]     = {1'b0, 8'h00, 16'h0202};
    cache_request_ready[1]   = 1'b1;
    txn(0, {1'b0, 8'h00, 16'h0101}, 16'hA0A0, 1, "t2a");
    tick();
    txn(1, {1'b0, 8'h00, 16'h0202}, 16'hB0B0, 2, "t2b");
    tick();
    // rr_pointer back at 0: port 0 must win a fresh contention
    cache_request_ready[1] = 1'b1;
    txn(0, {1'b0, 8'h00, 16'h0303}, 16'hC0C0, 0, "t2c");
    cache_request_ready[1] = 1'b0;
    check("t2_inval", invalidate_address, 32'd0);
    tick();

    // 3: port 1 write -> slot0 takes the address, slot1 untouched
    txn(1, {1'b1, 8'hA5, 16'h0442}, 16'h0001, 1, "t3");
    check("t3_slot0", 32'(invalidate_address[15:0]), 32'h0442);
    check("t3_slot1", 32'(invalidate_address[31:16]), 32'h0000);
    tick();
    check("t3_slot0_hold", 32'(invalidate_address[15:0]), 32'h0442);

    // 4: same address again -> one-cycle complement toggle on slot0
    txn(1, {1'b1, 8'hA5, 16'h0442}, 16'h0002, 1, "t4");
    check("t4_slot0_tgl", 32'(invalidate_address[15:0]), 32'hFB42);
    check("t4_slot1", 32'(invalidate_address[31:16]), 32'h0000);
    tick();
    check("t4_slot0_back", 32'(invalidate_address[15:0]), 32'h0442);

    // port 0 write -> slot1 changes, slot0 kept
    txn(0, {1'b1, 8'h3C, 16'h00AA}, 16'h0003, 0, "t4b");
    check("t4b_slot1", 32'(invalidate_address[31:16]), 32'h00AA);
    check("t4b_slot0", 32'(invalidate_address[15:0]), 32'h0442);
    tick();

    // 5: timeout on a port-0 write
    cache_request[24:0]    = {1'b1, 8'h77, 16'h5555};
    cache_request_ready[0] = 1'b1;
    wait_mreq("t5");
    check("t5_mreq", 32'(memory_request), 32'h1775555);
    check("t5_terr_before", 32'(timeout_error), 32'd0);
    cnt = 0;
    while (memory_request_ready && cnt < 300) begin
      tick();
      cnt++;
    end
    check("t5_wait_cycles", 32'(cnt), 32'd255);
    check("t5_terr", 32'(timeout_error), 32'd1);
    tick();
    check("t5_rdy", 32'(cache_response_ready), 32'b01);
    check("t5_resp", 32'(cache_response), 32'h0000);
    check("t5_inval", invalidate_address, {16'h00AA, 16'h0442});
    cache_request_ready[0] = 1'b0;
    tick();
    check("t5_terr_sticky", 32'(timeout_error), 32'd1);
    tick();

    // 6: reset asserted while waiting on memory
    cache_request[49:25]   = {1'b0, 8'h00, 16'h2222};
    cache_request_ready[1] = 1'b1;
    wait_mreq("t6");
    tick();
    tick();
    check("t6_mreq_rdy_pre", 32'(memory_request_ready), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_mreq_rdy", 32'(memory_request_ready), 32'd0);
    check("t6_mreq", 32'(memory_request), 32'd0);
    check("t6_terr", 32'(timeout_error), 32'd0);
    check("t6_inval", invalidate_address, 32'd0);
    check("t6_resp", 32'(cache_response), 32'd0);
    cache_request_ready = '0;
    tick();
    reset = 1'b1;
    tick();
    txn(0, {1'b0, 8'h00, 16'h3333}, 16'hCAFE, 2, "t6post");
    check("t6post_inval", invalidate_address, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
